// File: rtl/ddr3_playback_reader_pkg.sv
// Shared read command code, FSM state encoding and address step default for the playback reader.
// No logic of its own; latency and backpressure are not applicable.
package ddr3_playback_reader_pkg;

    localparam logic [2:0] CMD_READ      = 3'b001;
    localparam int         ADDR_STEP_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_CAL,
        S_ISSUE,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/ddr3_playback_reader_rd_word_buf.sv
// Synchronous DEPTH x WIDTH word FIFO with a show-ahead head word and an occupancy count.
// Push is visible one cycle later; push is dropped when full and pop is ignored when empty.
module rd_word_buf #(
    parameter int   DEPTH = 4,
    parameter int   WIDTH = 256,
    localparam int  CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && (count_q != FULL_CNT);
        do_pop   = pop_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ddr3_playback_reader.sv
// Streams a block of DDR3 words out as an LSB-first byte stream, optionally looping forever.
// Bytes start one cycle after a word lands; reads are throttled by MAX_OUT credits, bytes by sample_ready.
module ddr3_playback_reader
    import ddr3_playback_reader_pkg::*;
#(
    parameter int ADDR_W    = 29,
    parameter int DATA_W    = 256,
    parameter int ADDR_STEP = ADDR_STEP_DEF,
    parameter int MAX_OUT   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [15:0]       word_count,
    input  logic              loop_en,
    input  logic              init_calib_complete,
    output logic              app_en,
    output logic [2:0]        app_cmd,
    output logic [ADDR_W-1:0] app_addr,
    input  logic              app_rdy,
    input  logic [DATA_W-1:0] app_rd_data,
    input  logic              app_rd_data_valid,
    output logic [7:0]        sample_data,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              busy,
    output logic              done
);

    localparam int                BYTES    = DATA_W / 8;
    localparam int                IDX_W    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int                CNT_W    = $clog2(MAX_OUT + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BYTES - 1);
    localparam logic [CNT_W-1:0]  CREDITS  = CNT_W'(MAX_OUT);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [15:0]        len_q, len_d;
    logic [15:0]        rem_q, rem_d;
    logic [CNT_W-1:0]   credit_q, credit_d;
    logic [DATA_W-1:0]  ser_q, ser_d;
    logic               ser_vld_q, ser_vld_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               done_q, done_d;

    logic               cmd_en, cmd_acc, byte_hs, last_hs, ser_load, buf_push;
    logic [DATA_W-1:0]  buf_dout;
    logic [CNT_W-1:0]   buf_cnt;

    rd_word_buf #(
        .DEPTH (MAX_OUT),
        .WIDTH (DATA_W)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .push_i  (buf_push),
        .din_i   (app_rd_data),
        .pop_i   (ser_load),
        .dout_o  (buf_dout),
        .count_o (buf_cnt)
    );

    // credit_q counts reads in flight plus words parked in the buffer.
    assign cmd_en   = (state_q == S_ISSUE) && (credit_q < CREDITS);
    assign cmd_acc  = cmd_en && app_rdy;
    assign byte_hs  = ser_vld_q && sample_ready;
    assign last_hs  = byte_hs && (idx_q == LAST_IDX);
    assign ser_load = (!ser_vld_q || last_hs) && (buf_cnt != '0);
    assign buf_push = app_rd_data_valid && (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        base_d    = base_q;
        addr_d    = addr_q;
        len_d     = len_q;
        rem_d     = rem_q;
        credit_d  = credit_q;
        ser_d     = ser_q;
        ser_vld_d = ser_vld_q;
        idx_d     = idx_q;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count != 16'd0) begin
                        state_d = S_WAIT_CAL;
                        base_d  = start_addr;
                        addr_d  = start_addr;
                        len_d   = word_count;
                        rem_d   = word_count;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_WAIT_CAL: begin
                if (init_calib_complete) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_acc) begin
                    if (rem_q != 16'd1) begin
                        addr_d = addr_q + STEP;
                        rem_d  = rem_q - 16'd1;
                    end else if (loop_en) begin
                        addr_d = base_q;
                        rem_d  = len_q;
                    end else begin
                        addr_d  = addr_q + STEP;
                        rem_d   = '0;
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // No credits left means the serializer holds the very last word.
                if (last_hs && (credit_q == '0)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case ({cmd_acc, ser_load})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase

        if (ser_load) begin
            ser_d     = buf_dout;
            ser_vld_d = 1'b1;
            idx_d     = '0;
        end else if (last_hs) begin
            ser_vld_d = 1'b0;
        end else if (byte_hs) begin
            ser_d = ser_q >> 8;
            idx_d = idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            base_q    <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            rem_q     <= '0;
            credit_q  <= '0;
            ser_q     <= '0;
            ser_vld_q <= 1'b0;
            idx_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            base_q    <= base_d;
            addr_q    <= addr_d;
            len_q     <= len_d;
            rem_q     <= rem_d;
            credit_q  <= credit_d;
            ser_q     <= ser_d;
            ser_vld_q <= ser_vld_d;
            idx_q     <= idx_d;
            done_q    <= done_d;
        end
    end

    assign app_en       = cmd_en;
    assign app_cmd      = cmd_en ? CMD_READ : 3'b000;
    assign app_addr     = addr_q;
    assign sample_data  = ser_q[7:0];
    assign sample_valid = ser_vld_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;

endmodule

// File: tb/tb_ddr3_playback_reader.sv
// Randomized bench for ddr3_playback_reader against a queue-based model of addresses, bytes, done and busy.
module tb_ddr3_playback_reader;

    localparam int AW   = 29;
    localparam int DW   = 256;
    localparam int STEP = 8;
    localparam int MO   = 4;
    localparam int LAT  = 10;
    localparam int NB   = DW / 8;

    logic          clk = 1'b0;
    logic          reset, start, loop_en, init_calib_complete;
    logic [AW-1:0] start_addr;
    logic [15:0]   word_count;
    logic          app_en, app_rdy, app_rd_data_valid;
    logic [2:0]    app_cmd;
    logic [AW-1:0] app_addr;
    logic [DW-1:0] app_rd_data;
    logic [7:0]    sample_data;
    logic          sample_valid, sample_ready, busy, done;

    ddr3_playback_reader #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .ADDR_STEP (STEP),
        .MAX_OUT   (MO)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .start_addr          (start_addr),
        .word_count          (word_count),
        .loop_en             (loop_en),
        .init_calib_complete (init_calib_complete),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_rdy             (app_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .sample_data         (sample_data),
        .sample_valid        (sample_valid),
        .sample_ready        (sample_ready),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [DW-1:0] d;
    } ret_t;

    ret_t          ret_q[$];
    logic [7:0]    exp_q[$];
    logic [AW-1:0] acc_log[$];

    int n_checks = 0, n_err = 0, cyc_n = 0;
    int n_acc = 0, n_bytes = 0, m_wc = 0, done_due = -1;
    int first_hs = -1, last_hs = -1, done_cyc = -1, done_cnt = 0, en_cnt = 0, max_credit = 0;
    logic [AW-1:0] m_start = '0, prev_a = '0;
    logic [7:0]    prev_s = '0;
    bit            busy_exp = 1'b0, hold_s = 1'b0, hold_a = 1'b0;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, got, exp, cyc_n);
        end
    endtask

    // One bench cycle, run at a falling edge: drive the DDR return, check outputs, update the model.
    task automatic cyc();
        bit            busy_next;
        int            started, cr;
        logic [DW-1:0] d;
        logic [AW-1:0] ea;
        busy_next = busy_exp;

        if (ret_q.size() > 0 && ret_q[0].due <= cyc_n) begin
            app_rd_data_valid = 1'b1;
            app_rd_data       = ret_q[0].d;
            ret_q.delete(0);
        end else begin
            app_rd_data_valid = 1'b0;
            for (int j = 0; j < DW / 32; j++) app_rd_data[j*32 +: 32] = $urandom;
        end

        chk("done", done, cyc_n == done_due);
        if (done) begin
            done_cnt++;
            done_cyc = cyc_n;
        end
        chk("busy", busy, busy_exp);
        if (hold_s) begin
            chk("hold_valid", sample_valid, 1);
            chk("hold_data", sample_data, prev_s);
        end
        if (hold_a) begin
            chk("hold_en", app_en, 1);
            chk("hold_addr", app_addr, prev_a);
        end
        if (app_en) begin
            en_cnt++;
            chk("app_cmd", app_cmd, 3'b001);
        end

        started = n_bytes / NB + (sample_valid ? 1 : 0);
        cr      = n_acc - started;
        if (cr > max_credit) max_credit = cr;
        if (busy_exp) chk("credit_limit", cr <= MO, 1);

        if (app_en && app_rdy) begin
            if (m_wc == 0) begin
                chk("app_en_without_job", app_en, 0);
            end else begin
                if (!loop_en) chk("cmd_count", n_acc < m_wc, 1);
                ea = m_start + AW'(STEP * (n_acc % m_wc));
                chk("app_addr", app_addr, ea);
                acc_log.push_back(app_addr);
                for (int j = 0; j < DW / 32; j++) d[j*32 +: 32] = $urandom;
                ret_q.push_back('{cyc_n + LAT, d});
                for (int j = 0; j < NB; j++) exp_q.push_back(d[j*8 +: 8]);
                n_acc++;
            end
        end

        if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) chk("spurious_byte", sample_valid, 0);
            else chk("byte", sample_data, exp_q.pop_front());
            if (first_hs < 0) first_hs = cyc_n;
            last_hs = cyc_n;
            n_bytes++;
            if (!loop_en && m_wc != 0 && n_bytes == m_wc * NB) begin
                done_due  = cyc_n + 1;
                busy_next = 1'b0;
            end
        end

        if (start && !busy_exp && !reset) begin
            m_wc = int'(word_count);
            if (word_count == 16'd0) begin
                done_due = cyc_n + 1;
            end else begin
                busy_next  = 1'b1;
                m_start    = start_addr;
                n_acc      = 0;
                n_bytes    = 0;
                first_hs   = -1;
                last_hs    = -1;
                max_credit = 0;
                exp_q.delete();
                acc_log.delete();
            end
        end

        if (reset) begin
            busy_next = 1'b0;
            done_due  = -1;
            n_acc     = 0;
            n_bytes   = 0;
            m_wc      = 0;
            exp_q.delete();
        end

        hold_s   = sample_valid && !sample_ready && !reset;
        hold_a   = app_en && !app_rdy && !reset;
        prev_s   = sample_data;
        prev_a   = app_addr;
        busy_exp = busy_next;
        @(negedge clk);
        cyc_n++;
    endtask

    task automatic do_start(input logic [AW-1:0] sa, input int wc);
        start_addr = sa;
        word_count = 16'(wc);
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    task automatic run_to_done(input int budget, input int rdy_pct, input int srdy_pct);
        int base;
        int t;
        base = done_cnt;
        t    = 0;
        while (done_cnt == base && t < budget) begin
            app_rdy      = ($urandom_range(0, 99) < rdy_pct);
            sample_ready = ($urandom_range(0, 99) < srdy_pct);
            cyc();
            t++;
        end
        chk("run_reached_done", done_cnt != base, 1);
        app_rdy      = 1'b1;
        sample_ready = 1'b1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        int            wc, base, low_cnt, held, t;

        reset = 1'b1; start = 1'b0; loop_en = 1'b0; init_calib_complete = 1'b1;
        app_rdy = 1'b1; sample_ready = 1'b1; start_addr = '0; word_count = '0;
        app_rd_data_valid = 1'b0; app_rd_data = '0;
        @(negedge clk);
        cyc();
        cyc();
        chk("reset_outputs", {app_en, app_cmd, app_addr, sample_valid, busy, done}, '0);
        reset = 1'b0;
        cyc();

        // Basic three-word read with calibration arriving late.
        init_calib_complete = 1'b0;
        do_start(AW'('h100), 3);
        repeat (3) begin
            cyc();
            chk("wait_cal_no_en", app_en, 0);
        end
        init_calib_complete = 1'b1;
        run_to_done(400, 100, 100);
        chk("t1_n_acc", n_acc, 3);
        chk("t1_addr0", acc_log[0], 'h100);
        chk("t1_addr1", acc_log[1], 'h108);
        chk("t1_addr2", acc_log[2], 'h110);
        chk("t1_bytes", n_bytes, 96);
        chk("t1_no_bubble", last_hs - first_hs, 95);
        chk("t1_done_after_last", done_cyc, last_hs + 1);

        // Zero-length job.
        en_cnt = 0;
        base   = done_cnt;
        do_start(AW'('h200), 0);
        repeat (6) cyc();
        chk("t2_no_app_en", en_cnt, 0);
        chk("t2_done_once", done_cnt - base, 1);

        // app_rdy withheld for five cycles on the second command.
        do_start(AW'('h100), 3);
        low_cnt = 0; held = 0; t = 0; base = done_cnt;
        while (done_cnt == base && t < 400) begin
            app_rdy = 1'b1;
            if (n_acc == 1 && app_en && low_cnt < 5) begin
                app_rdy = 1'b0;
                low_cnt++;
                if (app_addr == AW'('h108)) held++;
            end
            cyc();
            t++;
        end
        app_rdy = 1'b1;
        chk("t4_done", done_cnt != base, 1);
        chk("t4_held_0x108", held, 5);
        chk("t4_n_acc", n_acc, 3);
        chk("t4_addr1", acc_log[1], 'h108);

        // Address wrap at the top of the space.
        do_start(AW'('h1FFFFFF8), 2);
        run_to_done(400, 100, 100);
        chk("t5_addr0", acc_log[0], 'h1FFFFFF8);
        chk("t5_addr1_wrapped", acc_log[1], 'h0);

        // Long sample stall: credits cap reads, data holds, nothing is lost.
        do_start(AW'('h2000), 10);
        sample_ready = 1'b0;
        repeat (200) cyc();
        chk("t3_acc_during_stall", n_acc, 5);
        chk("t3_max_credit", max_credit, 4);
        chk("t3_valid_held", sample_valid, 1);
        run_to_done(1000, 100, 100);
        chk("t3_bytes", n_bytes, 320);
        chk("t3_all_consumed", exp_q.size(), 0);

        // Random jobs with random backpressure on both sides.
        repeat (6) begin
            a  = AW'($urandom) & ~AW'(7);
            wc = $urandom_range(1, 8);
            do_start(a, wc);
            run_to_done(3000, 70, 60);
            chk("rnd_bytes", n_bytes, wc * NB);
        end

        // Looping playback, then reset mid-stream with returns still in flight.
        loop_en = 1'b1;
        a = AW'($urandom) & ~AW'(7);
        do_start(a, 2);
        t = 0;
        while (n_acc < 5 && t < 400) begin
            cyc();
            t++;
        end
        chk("t6_n_acc", n_acc, 5);
        chk("t6_addr0", acc_log[0], a);
        chk("t6_addr1", acc_log[1], a + AW'(8));
        chk("t6_addr2", acc_log[2], a);
        chk("t6_addr3", acc_log[3], a + AW'(8));
        chk("t6_addr4", acc_log[4], a);
        reset = 1'b1;
        cyc();
        chk("t6_reset_outputs_0", {app_en, app_cmd, app_addr, sample_valid, busy, done}, '0);
        cyc();
        chk("t6_reset_outputs_1", {app_en, app_cmd, app_addr, sample_valid, busy, done}, '0);
        loop_en = 1'b0;
        reset   = 1'b0;
        cyc();
        chk("t6_post_reset_outputs", {app_en, app_cmd, app_addr, sample_valid, busy, done}, '0);
        begin
            logic [DW-1:0] late;
            for (int j = 0; j < DW / 32; j++) late[j*32 +: 32] = $urandom;
            ret_q.push_back('{cyc_n, late});
        end
        repeat (20) begin
            cyc();
            chk("t6_late_discard", sample_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
